// File: rtl/sar_lt_value_recovery_pkg.sv
// rtl/sar_lt_value_recovery_pkg.sv - shared types, defaults and trial-word helper for the lt-oracle recovery engine
package sar_lt_value_recovery_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // One bit of the trial word: the recovered bit, or forced to 1 at the probe position.
  function automatic logic trial_bit(input logic res_bit, input int unsigned pos,
                                     input int unsigned idx);
    return res_bit | (pos == idx);
  endfunction

endpackage

// File: rtl/sar_lt_value_recovery.sv
// rtl/sar_lt_value_recovery.sv - MSB-first successive approximation of a secret from lt-oracle answers
module sar_lt_value_recovery
  import sar_lt_value_recovery_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             query_valid,
  input  logic             query_ready,
  output logic [WIDTH-1:0] query,
  input  logic             resp_valid,
  input  logic             resp_lt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] num_queries,
  output logic             proto_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] trial_w;
  logic [WIDTH-1:0] probe_mask;

  always_comb begin
    trial_w    = '0;
    probe_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      trial_w[i]    = trial_bit(result_q[i], i, 32'(idx_q));
      probe_mask[i] = (32'(idx_q) == i);
    end
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    query_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    // A response is only legal while waiting for one.
    if (resp_valid && state_q != S_WAIT) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          result_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
          idx_d    = CNT_W'(WIDTH - 1);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        query_valid = 1'b1;
        busy        = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (query_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (resp_valid) begin
          result_d = resp_lt ? (result_q & ~probe_mask) : (result_q | probe_mask);
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - CNT_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      idx_q    <= CNT_W'(WIDTH - 1);
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign query       = query_valid ? trial_w : '0;
  assign result      = result_q;
  assign num_queries = cnt_q;
  assign proto_err   = err_q;

endmodule
